// File: rtl/div_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : div_seq_ctrl_if
// Brief   : EX-stage request/response bundle between decode and div_seq_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
interface div_seq_ctrl_if #(
    parameter int XLEN = 64
);
    logic            req_valid_i;
    logic [2:0]      req_op_i;
    logic [XLEN-1:0] srcA_i;
    logic [XLEN-1:0] srcB_i;
    logic            flush_i;
    logic            hold_i;
    logic            stall_o;
    logic            resp_valid_o;
    logic [XLEN-1:0] result_o;
    logic            err_o;

    modport master (
        output req_valid_i, req_op_i, srcA_i, srcB_i, flush_i, hold_i,
        input  stall_o, resp_valid_o, result_o, err_o
    );

    modport slave (
        input  req_valid_i, req_op_i, srcA_i, srcB_i, flush_i, hold_i,
        output stall_o, resp_valid_o, result_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : div_seq_ctrl
// Brief   : Sequencer between RV64M divide decode and the iterative divider
//           core; resolves divide-by-zero/overflow locally, stalls EX until
//           done. Optional last-result cache enabled by DIV_RESULT_CACHE_EN.
// Revision: 1.0 - initial release
// ============================================================================
module div_seq_ctrl #(
    parameter int XLEN           = 64,
    parameter int TIMEOUT_CYCLES = 80
) (
    input  logic            clock,
    input  logic            reset,
    div_seq_ctrl_if.slave   ex,
    output logic            dv_start_o,
    output logic            dv_signed_o,
    output logic [XLEN-1:0] dv_a_o,
    output logic [XLEN-1:0] dv_b_o,
    input  logic            dv_ready_i,
    input  logic [XLEN-1:0] dv_q_i,
    input  logic [XLEN-1:0] dv_r_i
);

    localparam int              TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]   C_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [XLEN-1:0] C_X_MIN    = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] C_W_MIN    = {{(XLEN-31){1'b1}}, 31'd0};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SPECIAL = 3'd1,
        S_START   = 3'd2,
        S_BUSY    = 3'd3,
        S_DONE    = 3'd4,
        S_DRAIN   = 3'd5
    } state_e;

    function automatic logic [XLEN-1:0] prep(input logic [XLEN-1:0] x, input logic w, input logic uns);
        if (!w)      return x;
        else if (uns) return {{(XLEN-32){1'b0}}, x[31:0]};
        else          return {{(XLEN-32){x[31]}}, x[31:0]};
    endfunction

    function automatic logic [XLEN-1:0] fmt_res(input logic [XLEN-1:0] x, input logic w);
        return w ? {{(XLEN-32){x[31]}}, x[31:0]} : x;
    endfunction

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic            signed_q, signed_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            resp_valid_q, resp_valid_d;
    logic            err_q, err_d;
    logic            start_q, start_d;
    logic            tmo_q, tmo_d;

    logic [XLEN-1:0] w_a_prep, w_b_prep;
    logic            w_special;
    logic [XLEN-1:0] w_spec_q, w_spec_r;
    logic            w_hit;
    logic [XLEN-1:0] w_hit_result;

    assign w_a_prep = prep(ex.srcA_i, ex.req_op_i[2], ex.req_op_i[0]);
    assign w_b_prep = prep(ex.srcB_i, ex.req_op_i[2], ex.req_op_i[0]);

    // Prepared operands are already extended, so width-specific checks reduce to full-width compares.
    assign w_special = (w_b_prep == '0) ||
                       (!ex.req_op_i[0] && (&w_b_prep) &&
                        (w_a_prep == (ex.req_op_i[2] ? C_W_MIN : C_X_MIN)));

    assign w_spec_q = (b_q == '0) ? '1  : a_q;
    assign w_spec_r = (b_q == '0) ? a_q : '0;

`ifdef DIV_RESULT_CACHE_EN
    logic            cv_q, cv_d;
    logic            cs_q, cs_d, cw_q, cw_d;
    logic [XLEN-1:0] ca_q, ca_d, cb_q, cb_d, cq_q, cq_d, cr_q, cr_d;

    assign w_hit = cv_q && (ca_q == w_a_prep) && (cb_q == w_b_prep) &&
                   (cs_q == !ex.req_op_i[0]) && (cw_q == ex.req_op_i[2]);
    assign w_hit_result = fmt_res(ex.req_op_i[1] ? cr_q : cq_q, ex.req_op_i[2]);
`else
    assign w_hit        = 1'b0;
    assign w_hit_result = '0;
`endif

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        signed_d     = signed_q;
        timer_d      = timer_q;
        result_d     = result_q;
        resp_valid_d = resp_valid_q;
        err_d        = err_q;
        start_d      = 1'b0;
        tmo_d        = tmo_q;
`ifdef DIV_RESULT_CACHE_EN
        cv_d = cv_q;
        cs_d = cs_q;
        cw_d = cw_q;
        ca_d = ca_q;
        cb_d = cb_q;
        cq_d = cq_q;
        cr_d = cr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ex.req_valid_i && !ex.flush_i) begin
                    op_d     = ex.req_op_i;
                    a_d      = w_a_prep;
                    b_d      = w_b_prep;
                    signed_d = !ex.req_op_i[0];
                    tmo_d    = 1'b0;
                    err_d    = 1'b0;
                    if (w_hit) begin
                        result_d     = w_hit_result;
                        resp_valid_d = 1'b1;
                        state_d      = S_DONE;
                    end else if (w_special) begin
                        state_d = S_SPECIAL;
                    end else begin
                        start_d = 1'b1;
                        state_d = S_START;
                    end
                end
            end
            S_SPECIAL: begin
                result_d     = fmt_res(op_q[1] ? w_spec_r : w_spec_q, op_q[2]);
                resp_valid_d = 1'b1;
                state_d      = S_DONE;
`ifdef DIV_RESULT_CACHE_EN
                cv_d = 1'b1;
                ca_d = a_q;
                cb_d = b_q;
                cs_d = signed_q;
                cw_d = op_q[2];
                cq_d = w_spec_q;
                cr_d = w_spec_r;
`endif
            end
            S_START: begin
                timer_d = '0;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (dv_ready_i) begin
                    result_d     = fmt_res(op_q[1] ? dv_r_i : dv_q_i, op_q[2]);
                    resp_valid_d = 1'b1;
                    state_d      = S_DONE;
`ifdef DIV_RESULT_CACHE_EN
                    cv_d = 1'b1;
                    ca_d = a_q;
                    cb_d = b_q;
                    cs_d = signed_q;
                    cw_d = op_q[2];
                    cq_d = dv_q_i;
                    cr_d = dv_r_i;
`endif
                end else if (timer_q == C_TMO_LAST) begin
                    result_d     = '0;
                    resp_valid_d = 1'b1;
                    err_d        = 1'b1;
                    tmo_d        = 1'b1;
                    state_d      = S_DONE;
`ifdef DIV_RESULT_CACHE_EN
                    cv_d = 1'b0;
`endif
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DONE: begin
                if (!ex.hold_i) begin
                    resp_valid_d = 1'b0;
                    err_d        = 1'b0;
                    state_d      = tmo_q ? S_DRAIN : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (dv_ready_i) begin
                    tmo_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush overrides everything above, including a same-cycle dv_ready_i.
        if (ex.flush_i && state_q != S_DRAIN) begin
            start_d      = 1'b0;
            resp_valid_d = 1'b0;
            err_d        = 1'b0;
            tmo_d        = 1'b0;
            state_d      = (state_q == S_START || state_q == S_BUSY) ? S_DRAIN : S_IDLE;
        end
`ifdef DIV_RESULT_CACHE_EN
        if (ex.flush_i) cv_d = 1'b0;
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            signed_q     <= 1'b0;
            timer_q      <= '0;
            result_q     <= '0;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            start_q      <= 1'b0;
            tmo_q        <= 1'b0;
`ifdef DIV_RESULT_CACHE_EN
            cv_q <= 1'b0;
            cs_q <= 1'b0;
            cw_q <= 1'b0;
            ca_q <= '0;
            cb_q <= '0;
            cq_q <= '0;
            cr_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            signed_q     <= signed_d;
            timer_q      <= timer_d;
            result_q     <= result_d;
            resp_valid_q <= resp_valid_d;
            err_q        <= err_d;
            start_q      <= start_d;
            tmo_q        <= tmo_d;
`ifdef DIV_RESULT_CACHE_EN
            cv_q <= cv_d;
            cs_q <= cs_d;
            cw_q <= cw_d;
            ca_q <= ca_d;
            cb_q <= cb_d;
            cq_q <= cq_d;
            cr_q <= cr_d;
`endif
        end
    end

    assign ex.stall_o      = (ex.req_valid_i && state_q != S_DONE) || (state_q == S_DRAIN);
    assign ex.resp_valid_o = resp_valid_q;
    assign ex.result_o     = result_q;
    assign ex.err_o        = err_q;
    assign dv_start_o      = start_q;
    assign dv_signed_o     = signed_q;
    assign dv_a_o          = a_q;
    assign dv_b_o          = b_q;

endmodule
`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_div_seq_ctrl
// Brief   : Self-checking bench for div_seq_ctrl with a behavioural divider
//           core and a RISC-V M-extension reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_div_seq_ctrl;
    localparam int XLEN = 64;
    localparam int TMO  = 80;
`ifdef DIV_RESULT_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    div_seq_ctrl_if #(.XLEN(XLEN)) ex ();

    logic            dv_start, dv_signed;
    logic [XLEN-1:0] dv_a, dv_b;
    logic [XLEN-1:0] dv_q = '0;
    logic [XLEN-1:0] dv_r = '0;
    logic            core_rdy  = 1'b0;
    logic            force_rdy = 1'b0;
    logic            dv_ready;
    assign dv_ready = core_rdy | force_rdy;

    div_seq_ctrl #(.XLEN(XLEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clock       (clock),
        .reset       (reset),
        .ex          (ex),
        .dv_start_o  (dv_start),
        .dv_signed_o (dv_signed),
        .dv_a_o      (dv_a),
        .dv_b_o      (dv_b),
        .dv_ready_i  (dv_ready),
        .dv_q_i      (dv_q),
        .dv_r_i      (dv_r)
    );

    // Core model: ready rises core_lat edges after the edge that samples dv_start and stays high.
    int core_lat  = 1;
    bit core_hang = 1'b0;
    int core_cnt  = 0;
    int start_cnt = 0;
    always @(posedge clock) begin
        if (dv_start) begin
            start_cnt <= start_cnt + 1;
            core_rdy  <= 1'b0;
            core_cnt  <= core_hang ? 0 : core_lat;
            if (dv_b == '0) begin
                dv_q <= '0;
                dv_r <= '0;
            end else if (dv_signed) begin
                dv_q <= $signed(dv_a) / $signed(dv_b);
                dv_r <= $signed(dv_a) % $signed(dv_b);
            end else begin
                dv_q <= dv_a / dv_b;
                dv_r <= dv_a % dv_b;
            end
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) core_rdy <= 1'b1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [31:0]        ua32, ub32, r32;
        logic signed [31:0] sa32, sb32;
        logic signed [63:0] sa, sb;
        logic [63:0]        r64;
        if (op[2]) begin
            ua32 = a[31:0];
            ub32 = b[31:0];
            if (ub32 == 0)                                                  r32 = op[1] ? ua32 : 32'hFFFF_FFFF;
            else if (!op[0] && ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = op[1] ? 32'h0 : ua32;
            else if (op[0])                                                 r32 = op[1] ? ua32 % ub32 : ua32 / ub32;
            else begin
                sa32 = ua32;
                sb32 = ub32;
                r32  = op[1] ? sa32 % sb32 : sa32 / sb32;
            end
            return {{32{r32[31]}}, r32};
        end
        if (b == 0)                                              r64 = op[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1) r64 = op[1] ? 64'h0 : a;
        else if (op[0])                                          r64 = op[1] ? a % b : a / b;
        else begin
            sa  = a;
            sb  = b;
            r64 = op[1] ? sa % sb : sa / sb;
        end
        return r64;
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        if (op[2]) return (b[31:0] == 0) || (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 0) || (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1);
    endfunction

    function automatic logic [129:0] make_key(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] ma, mb;
        ma = op[2] ? {32'h0, a[31:0]} : a;
        mb = op[2] ? {32'h0, b[31:0]} : b;
        return {op[2], op[0], ma, mb};
    endfunction

    bit           cache_ok  = 1'b0;
    logic [129:0] cache_key = '0;

    task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input int lat, input int hold_n);
        logic [63:0] exp;
        bit          spec, hit, got, stall_ok;
        int          exp_lat, s0, cyc;
        exp      = ref_result(op, a, b);
        spec     = is_special(op, a, b);
        hit      = CACHE_EN && cache_ok && (cache_key == make_key(op, a, b));
        exp_lat  = hit ? 1 : (spec ? 2 : lat + 3);
        core_lat = lat;
        s0       = start_cnt;
        ex.req_valid_i = 1'b1;
        ex.req_op_i    = op;
        ex.srcA_i      = a;
        ex.srcB_i      = b;
        cyc = 0; got = 1'b0; stall_ok = 1'b1;
        while (!got && cyc < 400) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
            if (ex.resp_valid_o) got = 1'b1;
            else if (!ex.stall_o) stall_ok = 1'b0;
        end
        check("resp_seen",  64'(got), 64'd1);
        check("result",     ex.result_o, exp);
        check("err",        64'(ex.err_o), 64'd0);
        check("latency",    64'(cyc), 64'(exp_lat));
        check("start_cnt",  64'(start_cnt - s0), (hit || spec) ? 64'd0 : 64'd1);
        check("stall_busy", 64'(stall_ok), 64'd1);
        check("stall_done", 64'(ex.stall_o), 64'd0);
        ex.hold_i = 1'b1;
        repeat (hold_n) begin
            @(posedge clock);
            @(negedge clock);
            check("hold_valid",  64'(ex.resp_valid_o), 64'd1);
            check("hold_result", ex.result_o, exp);
        end
        ex.hold_i = 1'b0;
        @(posedge clock);
        #1;
        ex.req_valid_i = 1'b0;
        check("exit_valid", 64'(ex.resp_valid_o), 64'd0);
        cache_ok  = 1'b1;
        cache_key = make_key(op, a, b);
    endtask

    task automatic flush_test();
        bit rdy_seen, saw_resp, stall_bad;
        int s0;
        s0 = start_cnt;
        core_lat = 33;
        ex.req_valid_i = 1'b1;
        ex.req_op_i    = 3'b000;
        ex.srcA_i      = 64'd123456789;
        ex.srcB_i      = 64'd1000;
        @(posedge clock);
        repeat (10) @(posedge clock);
        #1;
        ex.flush_i     = 1'b1;
        ex.req_valid_i = 1'b0;
        @(posedge clock);
        #1;
        ex.flush_i = 1'b0;
        cache_ok   = 1'b0;
        rdy_seen = 1'b0; saw_resp = 1'b0; stall_bad = 1'b0;
        for (int i = 0; i < 100 && !rdy_seen; i++) begin
            @(negedge clock);
            if (ex.resp_valid_o) saw_resp = 1'b1;
            if (!ex.stall_o) stall_bad = 1'b1;
            if (dv_ready) rdy_seen = 1'b1;
        end
        check("flush_start_cnt", 64'(start_cnt - s0), 64'd1);
        check("flush_rdy_seen",  64'(rdy_seen), 64'd1);
        check("flush_no_resp",   64'(saw_resp), 64'd0);
        check("flush_stall",     64'(stall_bad), 64'd0);
        @(posedge clock);
        #1;
        check("flush_idle", 64'(ex.stall_o), 64'd0);
    endtask

    task automatic timeout_test();
        bit got, stall_bad;
        int cyc, s0;
        s0 = start_cnt;
        core_hang = 1'b1;
        ex.req_valid_i = 1'b1;
        ex.req_op_i    = 3'b000;
        ex.srcA_i      = 64'd1000;
        ex.srcB_i      = 64'd3;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 200) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
            if (ex.resp_valid_o) got = 1'b1;
        end
        check("tmo_resp_seen", 64'(got), 64'd1);
        check("tmo_latency",   64'(cyc), 64'(TMO + 2));
        check("tmo_err",       64'(ex.err_o), 64'd1);
        check("tmo_result",    ex.result_o, 64'd0);
        check("tmo_start_cnt", 64'(start_cnt - s0), 64'd1);
        ex.hold_i = 1'b1;
        repeat (3) begin
            @(posedge clock);
            @(negedge clock);
            check("tmo_hold_err", 64'({ex.resp_valid_o, ex.err_o}), 64'd3);
        end
        ex.hold_i = 1'b0;
        @(posedge clock);
        #1;
        ex.req_valid_i = 1'b0;
        cache_ok = 1'b0;
        stall_bad = 1'b0;
        repeat (5) begin
            @(negedge clock);
            if (!ex.stall_o || ex.resp_valid_o) stall_bad = 1'b1;
        end
        check("drain_stall", 64'(stall_bad), 64'd0);
        @(posedge clock);
        #1;
        force_rdy = 1'b1;
        @(posedge clock);
        #1;
        force_rdy = 1'b0;
        core_hang = 1'b0;
        check("drain_exit", 64'(ex.stall_o), 64'd0);
    endtask

    logic [2:0]  r_op;
    logic [63:0] r_a, r_b;

    initial begin
        ex.req_valid_i = 1'b0;
        ex.req_op_i    = 3'b000;
        ex.srcA_i      = '0;
        ex.srcB_i      = '0;
        ex.flush_i     = 1'b0;
        ex.hold_i      = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_resp_valid", 64'(ex.resp_valid_o), 64'd0);
        check("rst_err",        64'(ex.err_o), 64'd0);
        check("rst_start",      64'(dv_start), 64'd0);
        check("rst_result",     ex.result_o, 64'd0);
        check("rst_dv_ab",      dv_a | dv_b, 64'd0);
        check("rst_stall",      64'(ex.stall_o), 64'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        run_op(3'b000, 64'd100, 64'd7, 33, 0);
        run_op(3'b010, 64'd100, 64'd7, 33, 1);
        run_op(3'b001, 64'd5, 64'd0, 5, 0);
        run_op(3'b011, 64'd5, 64'd0, 5, 0);
        run_op(3'b100, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5, 0);
        run_op(3'b110, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5, 2);

        flush_test();
        run_op(3'b000, 64'd123456789, 64'd1000, 6, 0);

        timeout_test();
        run_op(3'b000, 64'd1000, 64'd3, 4, 0);

        r_op = 3'b000; r_a = 64'd1; r_b = 64'd1;
        for (int n = 0; n < 30; n++) begin
            int cat;
            cat = $urandom_range(0, 9);
            if (cat == 9) begin
                r_op[1] = ~r_op[1];
            end else begin
                r_op = 3'($urandom_range(0, 7));
                r_a  = {$urandom, $urandom} >> $urandom_range(0, 63);
                r_b  = {$urandom, $urandom} >> $urandom_range(0, 63);
                if (cat == 0) begin
                    r_b = r_op[2] ? {$urandom, 32'h0} : 64'h0;
                end else if (cat == 1) begin
                    r_a = r_op[2] ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    r_b = r_op[2] ? {$urandom, 32'hFFFF_FFFF} : '1;
                end else if (cat == 2) begin
                    r_a = {$urandom, $urandom};
                    r_b = 64'($urandom_range(1, 20));
                end
            end
            run_op(r_op, r_a, r_b, $urandom_range(1, 12), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
